// File: rtl/hpi_pkg.sv
// Shared types and constants for the EZ-OTG HPI access sequencer.
package hpi_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        RST_OTG,
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } hpi_state_t;

    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDR    = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

endpackage

// File: rtl/hpi_rr_arb.sv
// Two-way round-robin arbiter; the pointer moves past the winner on update.
module hpi_rr_arb
    import hpi_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    // prio_q = 0: port 0 wins a tie; 1: port 1 wins a tie
    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt    = req;
        prio_d = prio_q;
        if (req == 2'b11) begin
            gnt = prio_q ? 2'b10 : 2'b01;
        end
        if (update && gnt[0]) begin
            prio_d = 1'b1;
        end else if (update && gnt[1]) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/hpi_access_ctrl.sv
// HPI transaction sequencer: arbitrates two requesters, times CS/RD/WR strobes
// and runs the OTG chip reset sequence after reset or on request.
module hpi_access_ctrl
    import hpi_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned STROBE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES   = 2,
    parameter logic [15:0] RST_CYCLES    = 16'd1000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  req,
    input  logic [1:0]  req_we,
    input  logic [1:0]  req_addr0,
    input  logic [1:0]  req_addr1,
    input  logic [15:0] req_wdata0,
    input  logic [15:0] req_wdata1,
    input  logic        otg_reset_req,
    output logic [1:0]  ack,
    output logic [15:0] rdata,
    output logic        ready,
    output logic [1:0]  sw_address,
    output logic [15:0] sw_data_out,
    input  logic [15:0] sw_data_in,
    output logic        sw_r,
    output logic        sw_w,
    output logic        sw_cs,
    output logic        sw_reset
);

    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LOAD    = RST_CYCLES - 16'd1;
    // second HOLD cycle: pin data of the last strobe-low cycle has arrived
    localparam logic [CNT_W-1:0] HOLD_CAP    = CNT_W'(HOLD_CYCLES - 2);

    hpi_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             port_q, port_d;
    logic             we_q, we_d;
    logic [1:0]       addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic [15:0]      rdata_q, rdata_d;
    logic [1:0]       ack_q, ack_d;
    logic             ready_q, ready_d;
    logic             cs_n_q, cs_n_d;
    logic             r_n_q, r_n_d;
    logic             w_n_q, w_n_d;
    logic             rst_n_q, rst_n_d;
    logic [1:0]       gnt;
    logic             arb_update;

    hpi_rr_arb u_arb (
        .Clk    (Clk),
        .Reset  (Reset),
        .req    (req),
        .update (arb_update),
        .gnt    (gnt)
    );

    // Next state, shared counter and transaction registers
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q | otg_reset_req;
        port_d     = port_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        arb_update = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d = RST_OTG;
                    cnt_d   = RST_LOAD;
                    pend_d  = otg_reset_req;
                end else if (req != 2'b00) begin
                    arb_update = 1'b1;
                    state_d    = SETUP;
                    cnt_d      = SETUP_LOAD;
                    port_d     = gnt[1];
                    we_d       = gnt[1] ? req_we[1]  : req_we[0];
                    addr_d     = gnt[1] ? req_addr1  : req_addr0;
                    wdata_d    = gnt[1] ? req_wdata1 : req_wdata0;
                end
            end
            RST_OTG: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LOAD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            HOLD: begin
                if ((cnt_q == HOLD_CAP) && !we_q) begin
                    rdata_d = sw_data_in;
                end
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cs_n_d  = !(state_d inside {SETUP, STROBE, HOLD});
        r_n_d   = !((state_d == STROBE) && !we_d);
        w_n_d   = !((state_d == STROBE) && we_d);
        rst_n_d = (state_d != RST_OTG);
        ack_d   = (state_d == DONE) ? (port_d ? 2'b10 : 2'b01) : 2'b00;
        ready_d = (state_d == IDLE) && !pend_d;
    end

    // Reset leaves a pending OTG reset so the sequence starts on the first clock
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b1;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= '0;
            ready_q <= 1'b0;
            cs_n_q  <= 1'b1;
            r_n_q   <= 1'b1;
            w_n_q   <= 1'b1;
            rst_n_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            port_q  <= port_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            ready_q <= ready_d;
            cs_n_q  <= cs_n_d;
            r_n_q   <= r_n_d;
            w_n_q   <= w_n_d;
            rst_n_q <= rst_n_d;
        end
    end

    assign ack         = ack_q;
    assign rdata       = rdata_q;
    assign ready       = ready_q;
    assign sw_address  = addr_q;
    assign sw_data_out = wdata_q;
    assign sw_r        = r_n_q;
    assign sw_w        = w_n_q;
    assign sw_cs       = cs_n_q;
    assign sw_reset    = rst_n_q;

endmodule

// File: tb/tb_hpi_access_ctrl.sv
// Directed bench for hpi_access_ctrl with a two-register hpi_io_intf model.
module tb_hpi_access_ctrl;
    import hpi_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  req_we = 2'b00;
    logic [1:0]  req_addr0 = 2'd0;
    logic [1:0]  req_addr1 = 2'd0;
    logic [15:0] req_wdata0 = 16'h0;
    logic [15:0] req_wdata1 = 16'h0;
    logic        otg_reset_req = 1'b0;
    logic [1:0]  ack;
    logic [15:0] rdata;
    logic        ready;
    logic [1:0]  sw_address;
    logic [15:0] sw_data_out;
    logic [15:0] sw_data_in = 16'h0;
    logic        sw_r, sw_w, sw_cs, sw_reset;

    hpi_access_ctrl #(.RST_CYCLES(16'd10)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .req_we(req_we),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .otg_reset_req(otg_reset_req), .ack(ack), .rdata(rdata), .ready(ready),
        .sw_address(sw_address), .sw_data_out(sw_data_out), .sw_data_in(sw_data_in),
        .sw_r(sw_r), .sw_w(sw_w), .sw_cs(sw_cs), .sw_reset(sw_reset)
    );

    always #5 Clk = ~Clk;

    // io_intf model: RD pin one register late, read data one more register late
    logic rd_pin = 1'b1;
    always @(posedge Clk) begin
        rd_pin     <= sw_r;
        sw_data_in <= rd_pin ? 16'h0000 : 16'hBEEF;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    int cs_cnt, w_first, w_last, w_cnt, r_cnt, ack_k, bad;
    logic [1:0]  ack_val;
    logic [15:0] rd_at_ack;
    int ack_at[4];
    logic [1:0] ack_v[4];
    int setup_at[4];

    task automatic drive_port(input logic p, input logic we, input logic [1:0] a, input logic [15:0] d);
        if (!p) begin
            req_we[0] = we; req_addr0 = a; req_wdata0 = d; req[0] = 1'b1;
        end else begin
            req_we[1] = we; req_addr1 = a; req_wdata1 = d; req[1] = 1'b1;
        end
    endtask

    task automatic wait_ready(input string tag);
        for (int k = 0; k < 2000; k++) begin
            @(negedge Clk);
            if (ready) break;
        end
        check(tag, 32'(ready), 32'd1);
    endtask

    // Single transaction; cycle k counts negedges after the request is driven
    task automatic do_txn(input logic p, input logic we, input logic [1:0] a, input logic [15:0] d);
        cs_cnt = 0; w_first = 0; w_last = 0; w_cnt = 0; r_cnt = 0; ack_k = 0; bad = 0;
        ack_val = 2'b00; rd_at_ack = 16'h0;
        drive_port(p, we, a, d);
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clk);
            if (!sw_cs) begin
                cs_cnt++;
                if (sw_address !== a || sw_data_out !== d) bad++;
            end
            if (!sw_w) begin
                if (w_first == 0) w_first = k;
                w_last = k;
                w_cnt++;
            end
            if (!sw_r) r_cnt++;
            if (ack != 2'b00) begin
                ack_k = k; ack_val = ack; rd_at_ack = rdata;
                req = 2'b00;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rst_low, rst_first, cs_in_rst, a0, a1, nack, nsetup, ack_in_rst;
        logic cs_prev;
        logic [15:0] rdv;
        logic [1:0] first_ack;

        // Reset values
        repeat (3) @(negedge Clk);
        check("rst_cs", 32'(sw_cs), 32'd1);
        check("rst_r", 32'(sw_r), 32'd1);
        check("rst_w", 32'(sw_w), 32'd1);
        check("rst_swreset", 32'(sw_reset), 32'd1);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_addr", 32'(sw_address), 32'd0);
        check("rst_dout", 32'(sw_data_out), 32'd0);
        Reset = 1'b0;

        // OTG reset sequence
        rst_low = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge Clk);
            if (!sw_reset) rst_low++;
            else if (rst_low > 0) break;
        end
        check("otg_rst_len", 32'(rst_low), 32'd10);
        check("otg_rst_ready", 32'(ready), 32'd1);
        check("otg_rst_cs", 32'(sw_cs), 32'd1);
        check("otg_rst_rw", {30'd0, sw_r, sw_w}, 32'd3);

        // Port-0 write
        do_txn(1'b0, 1'b1, HPI_ADDR, 16'h1234);
        check("wr_ack_cycle", 32'(ack_k), 32'd9);
        check("wr_ack_port", 32'(ack_val), 32'd1);
        check("wr_cs_len", 32'(cs_cnt), 32'd8);
        check("wr_w_first", 32'(w_first), 32'd3);
        check("wr_w_last", 32'(w_last), 32'd6);
        check("wr_w_len", 32'(w_cnt), 32'd4);
        check("wr_r_idle", 32'(r_cnt), 32'd0);
        check("wr_bus_stable", 32'(bad), 32'd0);
        check("wr_rdata_kept", 32'(rd_at_ack), 32'd0);

        // Port-1 read
        wait_ready("ready_before_rd");
        do_txn(1'b1, 1'b0, HPI_MAILBOX, 16'h5555);
        check("rd_ack_cycle", 32'(ack_k), 32'd9);
        check("rd_ack_port", 32'(ack_val), 32'd2);
        check("rd_r_len", 32'(r_cnt), 32'd4);
        check("rd_w_idle", 32'(w_cnt), 32'd0);
        check("rd_data", 32'(rd_at_ack), 32'hBEEF);
        wait_ready("ready_after_rd");
        repeat (2) @(negedge Clk);
        check("rd_data_hold", 32'(rdata), 32'hBEEF);

        // Simultaneous requests
        drive_port(1'b0, 1'b1, HPI_DATA, 16'hA0A0);
        drive_port(1'b1, 1'b1, HPI_STATUS, 16'h0B0B);
        nack = 0; nsetup = 0; cs_prev = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge Clk);
            if (cs_prev && !sw_cs && nsetup < 4) begin
                setup_at[nsetup] = k;
                nsetup++;
            end
            cs_prev = sw_cs;
            if (ack != 2'b00) begin
                ack_at[nack] = k;
                ack_v[nack] = ack;
                nack++;
                if (nack == 4) begin
                    req = 2'b00;
                    break;
                end
            end
        end
        check("rr_count", 32'(nack), 32'd4);
        check("rr_first_ack", 32'(ack_at[0]), 32'd9);
        check("rr_g0", 32'(ack_v[0]), 32'd1);
        check("rr_g1", 32'(ack_v[1]), 32'd2);
        check("rr_g2", 32'(ack_v[2]), 32'd1);
        check("rr_g3", 32'(ack_v[3]), 32'd2);
        for (int i = 1; i < 4; i++)
            check($sformatf("rr_gap%0d", i), 32'(setup_at[i] - ack_at[i-1]), 32'd2);

        // OTG reset request during the strobe of a write
        wait_ready("ready_before_otg");
        drive_port(1'b0, 1'b1, HPI_ADDR, 16'hC0DE);
        rst_first = 0; rst_low = 0; cs_in_rst = 0; a0 = 0; a1 = 0; rdv = 16'h0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge Clk);
            if (k == 4) begin
                check("otg_in_strobe", 32'(sw_w), 32'd0);
                otg_reset_req = 1'b1;
                drive_port(1'b1, 1'b0, HPI_DATA, 16'h0000);
            end else begin
                otg_reset_req = 1'b0;
            end
            if (k == 10) check("otg_not_ready", 32'(ready), 32'd0);
            if (!sw_reset) begin
                if (rst_first == 0) rst_first = k;
                rst_low++;
                if (!sw_cs) cs_in_rst++;
            end
            if (ack[0] && a0 == 0) begin
                a0 = k;
                req[0] = 1'b0;
            end
            if (ack[1]) begin
                a1 = k;
                rdv = rdata;
                req[1] = 1'b0;
                break;
            end
        end
        check("otg_wr_ack", 32'(a0), 32'd9);
        check("otg_rst_start", 32'(rst_first), 32'd11);
        check("otg_rst_len2", 32'(rst_low), 32'd10);
        check("otg_no_cs_in_rst", 32'(cs_in_rst), 32'd0);
        check("otg_p1_ack", 32'(a1), 32'd30);
        check("otg_p1_data", 32'(rdv), 32'hBEEF);

        // Async reset in HOLD
        wait_ready("ready_before_async");
        drive_port(1'b0, 1'b0, HPI_MAILBOX, 16'h0000);
        repeat (7) @(negedge Clk);
        check("async_in_hold", 32'(sw_cs), 32'd0);
        Reset = 1'b1;
        #1;
        check("async_strobes", {29'd0, sw_cs, sw_r, sw_w}, 32'd7);
        check("async_ack", 32'(ack), 32'd0);
        check("async_rdata", 32'(rdata), 32'd0);
        check("async_addr", 32'(sw_address), 32'd0);
        drive_port(1'b1, 1'b0, HPI_DATA, 16'h0000);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        rst_low = 0; ack_in_rst = 0; a1 = 0; first_ack = 2'b00;
        for (int k = 1; k <= 100; k++) begin
            @(negedge Clk);
            if (!sw_reset) rst_low++;
            if (ack != 2'b00) begin
                if (rst_low < 10) ack_in_rst++;
                a1 = k;
                first_ack = ack;
                req = 2'b00;
                break;
            end
        end
        check("async_rst_len", 32'(rst_low), 32'd10);
        check("async_no_early_ack", 32'(ack_in_rst), 32'd0);
        check("async_ack_cycle", 32'(a1), 32'd20);
        check("async_ptr_port0", 32'(first_ack), 32'd1);
        wait_ready("ready_final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
